// File: rtl/serial_subtractor.sv
// Digit-serial 32-bit subtractor: in_1 - in_2 - b_in, DIGIT_W bits per clock, LSB slice first.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_FLAG_EN is defined.
module serial_subtractor #(
    parameter int DIGIT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] in_1,
    input  logic [31:0] in_2,
    input  logic        b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] diff,
    output logic        b_out
`ifdef SERIAL_SUB_OVF_FLAG_EN
    ,
    output logic        ovf
`endif
);

    localparam int N     = 32 / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 32 - DIGIT_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic               last;
    logic [31:0]        op_a, op_b;
    logic [ACC_W-1:0]   acc;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT_W:0]   slice_p0;
    logic [31:0]        diff_nxt;
`ifdef SERIAL_SUB_OVF_FLAG_EN
    logic               a_msb, b_msb;
`endif

    // Top bit of the (DIGIT_W+1)-bit result is the slice borrow-out.
    function automatic logic [DIGIT_W:0] sub_slice(input logic [DIGIT_W-1:0] a,
                                                    input logic [DIGIT_W-1:0] b,
                                                    input logic               bi);
        return {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bi};
    endfunction

    assign accept   = start && (state != BUSY);
    assign last     = (cnt == CNT_W'(N - 1));
    assign slice_p0 = sub_slice(op_a[DIGIT_W-1:0], op_b[DIGIT_W-1:0], borrow);
    assign diff_nxt = {slice_p0[DIGIT_W-1:0], acc};
    assign busy     = (state == BUSY);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands shift right one digit per BUSY cycle; finished slices enter acc from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            b_out  <= 1'b0;
`ifdef SERIAL_SUB_OVF_FLAG_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            op_a   <= in_1;
            op_b   <= in_2;
            acc    <= '0;
            borrow <= b_in;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_FLAG_EN
            a_msb  <= in_1[31];
            b_msb  <= in_2[31];
`endif
        end else if (state == BUSY) begin
            op_a   <= op_a >> DIGIT_W;
            op_b   <= op_b >> DIGIT_W;
            acc    <= diff_nxt[31:DIGIT_W];
            borrow <= slice_p0[DIGIT_W];
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                diff  <= diff_nxt;
                b_out <= slice_p0[DIGIT_W];
`ifdef SERIAL_SUB_OVF_FLAG_EN
                // Overflow = borrow into bit 31 XOR borrow out of bit 31.
                ovf   <= a_msb ^ b_msb ^ slice_p0[DIGIT_W-1] ^ slice_p0[DIGIT_W];
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (DIGIT_W=4): vector table plus overlap/reset sequences.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in_1 = '0;
    logic [31:0] in_2 = '0;
    logic        b_in = 1'b0;
    logic        busy, done, b_out;
    logic [31:0] diff;
`ifdef SERIAL_SUB_OVF_FLAG_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.DIGIT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in_1  (in_1),
        .in_2  (in_2),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out)
`ifdef SERIAL_SUB_OVF_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] exp_diff;
        logic        exp_bout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Launch an operation and watch 20 edges; optionally pulse start again at edge mid.
    task automatic run_watch(input logic [31:0] a, input logic [31:0] b, input logic bi,
                             input int mid, input logic [31:0] a2, input logic [31:0] b2,
                             output int first_done, output int n_done,
                             output logic [31:0] c_diff, output logic c_bout, output logic c_ovf);
        first_done = 0;
        n_done = 0;
        c_diff = '0;
        c_bout = 1'b0;
        c_ovf = 1'b0;
        in_1 = a; in_2 = b; b_in = bi; start = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                start = 1'b0;
                in_1 = 32'hDEAD_BEEF; in_2 = 32'h1357_9BDF; b_in = ~bi;
            end
            if (mid != 0 && e == mid) begin
                start = 1'b1; in_1 = a2; in_2 = b2;
            end
            if (mid != 0 && e == mid + 1) start = 1'b0;
            if (done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = e;
                    c_diff = diff;
                    c_bout = b_out;
`ifdef SERIAL_SUB_OVF_FLAG_EN
                    c_ovf = ovf;
`endif
                end
            end
        end
    endtask

    initial begin
        int fd, nd, e;
        logic [31:0] cd;
        logic cb, co;

        vecs[0] = '{32'd546546,    32'd123564,    1'b0, 32'h0006_7446, 1'b0, 1'b0};
        vecs[1] = '{32'd123564,    32'd546546,    1'b0, 32'hFFF9_8BBA, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        vecs[6] = '{32'h1234_5678, 32'h0234_5678, 1'b1, 32'h0FFF_FFFF, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, 1'b0};
        vecs[8] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'h4B4B_4B4B, 1'b0, 1'b1};

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", diff, 32'd0);
        check("rst_bout", {31'd0, b_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_FLAG_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table
        foreach (vecs[i]) begin
            run_watch(vecs[i].a, vecs[i].b, vecs[i].bi, 0, '0, '0, fd, nd, cd, cb, co);
            check($sformatf("v%0d_latency", i), fd, 32'd9);
            check($sformatf("v%0d_pulses", i), nd, 32'd1);
            check($sformatf("v%0d_diff", i), cd, vecs[i].exp_diff);
            check($sformatf("v%0d_bout", i), {31'd0, cb}, {31'd0, vecs[i].exp_bout});
`ifdef SERIAL_SUB_OVF_FLAG_EN
            check($sformatf("v%0d_ovf", i), {31'd0, co}, {31'd0, vecs[i].exp_ovf});
`endif
            @(negedge clk);
        end

        // Start re-asserted 3 cycles into BUSY is ignored
        run_watch(32'd546546, 32'd123564, 1'b0, 3, 32'hFFFF_0000, 32'h0000_FFFF, fd, nd, cd, cb, co);
        check("busy_start_latency", fd, 32'd9);
        check("busy_start_pulses", nd, 32'd1);
        check("busy_start_diff", cd, 32'h0006_7446);
        check("busy_start_bout", {31'd0, cb}, 32'd0);
        @(negedge clk);

        // Back-to-back: start accepted in DONE
        in_1 = 32'd546546; in_2 = 32'd123564; b_in = 1'b0; start = 1'b1;
        e = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (done) begin e = k; break; end
        end
        check("b2b_first_latency", e, 32'd9);
        check("b2b_first_diff", diff, 32'h0006_7446);
        in_1 = 32'd123564; in_2 = 32'd546546; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy_after_done", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        e = 0;
        for (int k = 2; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin e = k; break; end
        end
        check("b2b_second_latency", e, 32'd9);
        check("b2b_second_diff", diff, 32'hFFF9_8BBA);
        check("b2b_second_bout", {31'd0, b_out}, 32'd1);
        @(negedge clk);

        // Reset 4 cycles into BUSY aborts the operation
        in_1 = 32'h0000_0000; in_2 = 32'h0000_0000; b_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_diff", diff, 32'd0);
        check("abort_bout", {31'd0, b_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        check("abort_no_done", nd, 32'd0);
        @(negedge clk);
        run_watch(32'd123564, 32'd546546, 1'b0, 0, '0, '0, fd, nd, cd, cb, co);
        check("post_reset_latency", fd, 32'd9);
        check("post_reset_diff", cd, 32'hFFF9_8BBA);
        check("post_reset_bout", {31'd0, cb}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
